seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 Parameter DIV, default 50000: clk cycles per digit slot, >= 2.
REQ-003 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  scan enable; 0 freezes the scan and blanks the display.
REQ-007 load  input  1  single-cycle strobe; captures din and dp_in.
REQ-008 din  input  4*DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
REQ-009 dp_in  input  DIGITS  per-digit decimal point, bit i for digit i.
REQ-010 seg  output  7  segments a..g on bits 6..0, active-high, registered.
REQ-011 dp  output  1  decimal point of the digit currently driven, registered.
REQ-012 an  output  DIGITS  one-hot digit enable, active-high, registered.
REQ-013 frame  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 Prescaler cnt counts 0..DIV-1 while en=1, wraps to 0, and holds while en=0.
REQ-015 tick is asserted when en=1 and cnt=DIV-1.
REQ-016 On tick, digit index idx advances 0..DIGITS-1 and wraps to 0.
REQ-017 A frame boundary is a tick with idx=DIGITS-1.
REQ-018 load=1 writes din and dp_in into the shadow register on that edge.
REQ-019 On a frame boundary, the active register takes din/dp_in if load=1 on the same edge; otherwise it takes the shadow register. The display never changes mid-frame.
REQ-020 An active digit is blanked when BLANK_LZ=1, i>0, and digit i and every higher digit are 0.
REQ-021 Digit 0 is never blanked.
REQ-022 A blanked digit drives seg=0000000 and dp=0, with its an bit still asserted.
REQ-023 Nibbles 10..15 decode to seg=0000000 and count as non-zero for blanking.
REQ-024 Decode table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-025 Dead time: when cnt=0, the next-cycle an is all-zero, seg=0, and dp=0.
REQ-026 Otherwise the next-cycle outputs are an=onehot(idx), seg=decode(active digit idx), and dp=active dp[idx].
REQ-027 Outputs lag the internal cnt/idx state by exactly 1 cycle.
REQ-028 en=0: an, seg and dp are 0 from the next cycle; cnt, idx and the active register hold.
REQ-029 en=0: load still writes the shadow register.
REQ-030 frame is registered and is 1 for exactly the cycle after a frame-boundary edge.

Reset
REQ-031 rst=1 clears cnt, idx, the shadow register, the active register, seg, dp, an and frame to 0 on the next edge.
REQ-032 rst has priority over load and en.
REQ-033 After rst deasserts, scanning restarts at slot 0 with cnt=0, and the active digits are all 0.

Structure
REQ-034 A shared package holds the 7-bit segment codes (SEG_BLANK and digits 0..9) and the DIV/DIGITS defaults.
REQ-035 One combinational decoder sub-module, BCD7 (din[3:0] -> dout[6:0], per REQ-023/024), is instantiated once and time-shared through an idx-driven nibble mux.
REQ-036 No per-digit decoders.

Verification
Common setup for all scenarios: DIGITS=4, DIV=4, BLANK_LZ=1.
REQ-037 Basic scan: rst, en=1, load din=0x1234, run to the first frame boundary. Required per slot:
- an=0001, seg=0110011
- an=0010, seg=1111001
- an=0100, seg=1101101
- an=1000, seg=0110000
- each an active 3 of 4 cycles
- frame pulses once per 16 cycles.
REQ-038 Leading-zero blanking:
- din=0x0070: digits 3 and 2 seg=0000000 with an asserted; digit 1 seg=1110000; digit 0 seg=1111110.
- din=0x0000: only digit 0 shows 1111110.
REQ-039 Invalid nibble: din=0x00A5 -> digit 1 seg=0000000; digits 3 and 2 blanked; digit 0 seg=1011011.
REQ-040 Load timing:
- load 0x1111 during slot 1: display unchanged until after the frame boundary.
- load 0x2222 coincident with a frame-boundary edge: slot 0 immediately shows 1101101.
REQ-041 Enable hold: en=0 mid-slot 2 -> an=0000 next cycle and cnt/idx frozen; en=1 -> resumes slot 2 at the frozen cnt.
REQ-042 Reset mid-scan: rst=1 for 1 cycle during slot 2 with load=1 -> next cycle an=0000, seg=0, frame=0, shadow=0; first new slot is digit 0 showing 1111110.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment codes
// (a..g on bits 6..0, active-high) and parameter defaults.
package seg_scan_ctrl_pkg;

  typedef logic [6:0] seg_t;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_DIV    = 50000;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;

endpackage

// File: rtl/seg_scan_ctrl_bcd7.sv
// Combinational BCD to 7-segment decoder; non-decimal nibbles go dark.
module seg_scan_ctrl_bcd7
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] din,
  output logic [6:0] dout
);

  always_comb begin
    dout = SEG_BLANK;
    case (din)
      4'd0:    dout = SEG_0;
      4'd1:    dout = SEG_1;
      4'd2:    dout = SEG_2;
      4'd3:    dout = SEG_3;
      4'd4:    dout = SEG_4;
      4'd5:    dout = SEG_5;
      4'd6:    dout = SEG_6;
      4'd7:    dout = SEG_7;
      4'd8:    dout = SEG_8;
      4'd9:    dout = SEG_9;
      default: dout = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit rotation, shadow/active
// double buffering swapped only at frame boundaries, leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS   = DEF_DIGITS,
  parameter int DIV      = DEF_DIV,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [DIGITS-1:0][3:0]    shd_nib, act_nib;
  logic [DIGITS-1:0]         shd_dp, act_dp;

  logic                      tick, last, boundary;
  logic [DIGITS-1:0]         lz;
  logic                      blank_cur;
  logic [3:0]                nib_cur;
  logic [6:0]                seg_dec;

  assign tick     = en && (cnt == CW'(DIV - 1));
  assign last     = (idx == IW'(DIGITS - 1));
  assign boundary = tick && last;

  // Prescaler and digit index; both freeze while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
        idx <= last ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_nib <= '0;
      shd_dp  <= '0;
    end else if (load) begin
      shd_nib <= din;
      shd_dp  <= dp_in;
    end
  end

  // A load on the boundary edge bypasses the shadow so it shows this frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_nib <= '0;
      act_dp  <= '0;
    end else if (boundary) begin
      act_nib <= load ? din   : shd_nib;
      act_dp  <= load ? dp_in : shd_dp;
    end
  end

  // lz[i]: digit i and everything above it are zero.
  always_comb begin
    logic acc;
    acc = 1'b1;
    lz  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc   = acc && (act_nib[i] == 4'd0);
      lz[i] = acc;
    end
  end

  assign nib_cur   = act_nib[idx];
  assign blank_cur = (BLANK_LZ != 0) && (idx != '0) && lz[idx];

  seg_scan_ctrl_bcd7 u_bcd7 (
    .din  (nib_cur),
    .dout (seg_dec)
  );

  // Slot's first cycle (cnt==0) is dead time to avoid ghosting between digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= '0;
      seg   <= SEG_BLANK;
      dp    <= 1'b0;
      frame <= 1'b0;
    end else begin
      frame <= boundary;
      if (!en || cnt == '0) begin
        an  <= '0;
        seg <= SEG_BLANK;
        dp  <= 1'b0;
      end else begin
        an  <= DIGITS'(1) << idx;
        seg <= blank_cur ? SEG_BLANK : seg_dec;
        dp  <= !blank_cur && act_dp[idx];
      end
    end
  end

endmodule
